// File: rtl/queue_dequeue_scheduler.sv
// Round-robin dequeue scheduler: doorbells mark queues active, one dequeue request at a time, responses
// forwarded to descriptor fetch, completions returned as commits. Optional DEQ_SCHED_STATS_EN adds counters.
module queue_dequeue_scheduler #(
    parameter int QUEUE_INDEX_WIDTH = 4,
    parameter int REQ_TAG_WIDTH     = 8,
    parameter int OP_TAG_WIDTH      = 4,
    parameter int ADDR_WIDTH        = 64,
    parameter int PTR_WIDTH         = 16,
    parameter int MAX_INFLIGHT      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,

    input  logic [QUEUE_INDEX_WIDTH-1:0]         s_axis_doorbell_queue,
    input  logic                                 s_axis_doorbell_valid,

    output logic [QUEUE_INDEX_WIDTH-1:0]         m_axis_dequeue_req_queue,
    output logic [REQ_TAG_WIDTH-1:0]             m_axis_dequeue_req_tag,
    output logic                                 m_axis_dequeue_req_valid,
    input  logic                                 m_axis_dequeue_req_ready,

    input  logic [QUEUE_INDEX_WIDTH-1:0]         s_axis_dequeue_resp_queue,
    input  logic [PTR_WIDTH-1:0]                 s_axis_dequeue_resp_ptr,
    input  logic [ADDR_WIDTH-1:0]                s_axis_dequeue_resp_addr,
    input  logic [REQ_TAG_WIDTH-1:0]             s_axis_dequeue_resp_tag,
    input  logic [OP_TAG_WIDTH-1:0]              s_axis_dequeue_resp_op_tag,
    input  logic                                 s_axis_dequeue_resp_empty,
    input  logic                                 s_axis_dequeue_resp_error,
    input  logic                                 s_axis_dequeue_resp_valid,
    output logic                                 s_axis_dequeue_resp_ready,

    output logic [QUEUE_INDEX_WIDTH-1:0]         m_axis_desc_req_queue,
    output logic [PTR_WIDTH-1:0]                 m_axis_desc_req_ptr,
    output logic [ADDR_WIDTH-1:0]                m_axis_desc_req_addr,
    output logic [OP_TAG_WIDTH-1:0]              m_axis_desc_req_op_tag,
    output logic                                 m_axis_desc_req_valid,
    input  logic                                 m_axis_desc_req_ready,

    input  logic [OP_TAG_WIDTH-1:0]              s_axis_desc_done_op_tag,
    input  logic                                 s_axis_desc_done_valid,
    output logic                                 s_axis_desc_done_ready,

    output logic [OP_TAG_WIDTH-1:0]              m_axis_dequeue_commit_op_tag,
    output logic                                 m_axis_dequeue_commit_valid,
    input  logic                                 m_axis_dequeue_commit_ready,

    output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight_count
`ifdef DEQ_SCHED_STATS_EN
    ,
    output logic [31:0]                          stat_req_count,
    output logic [31:0]                          stat_empty_count,
    output logic [31:0]                          stat_error_count
`endif
);

    localparam int NQ = 2**QUEUE_INDEX_WIDTH;
    localparam int CW = $clog2(MAX_INFLIGHT+1);

    typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_REQ} state_t;

    state_t                         state, state_nxt;
    logic [NQ-1:0]                  active, active_nxt;
    logic [QUEUE_INDEX_WIDTH-1:0]   rr_ptr;
    logic [REQ_TAG_WIDTH-1:0]       tag_cnt;
    logic [QUEUE_INDEX_WIDTH-1:0]   pick_idx;
    logic                           pick_found;
    logic                           arb_take;
    logic                           req_hs;
    logic                           resp_hs;
    logic                           resp_drop;
    logic                           done_hs;

    // Request tags are echoed back for the downstream's bookkeeping; the scheduler never matches on them.
    logic                           unused_resp_tag;
    assign unused_resp_tag = ^s_axis_dequeue_resp_tag;

    assign m_axis_dequeue_req_valid  = (state == ST_REQ);
    assign req_hs                    = m_axis_dequeue_req_valid && m_axis_dequeue_req_ready;
    assign s_axis_dequeue_resp_ready = !m_axis_desc_req_valid || m_axis_desc_req_ready;
    assign resp_hs                   = s_axis_dequeue_resp_valid && s_axis_dequeue_resp_ready;
    assign resp_drop                 = s_axis_dequeue_resp_empty || s_axis_dequeue_resp_error;
    assign s_axis_desc_done_ready    = !m_axis_dequeue_commit_valid || m_axis_dequeue_commit_ready;
    assign done_hs                   = s_axis_desc_done_valid && s_axis_desc_done_ready;

    // Lowest active index at or after rr_ptr; index arithmetic wraps naturally at the queue-index width.
    always_comb begin
        logic [QUEUE_INDEX_WIDTH-1:0] idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        for (int i = 0; i < NQ; i++) begin
            idx = rr_ptr + QUEUE_INDEX_WIDTH'(i);
            if (!pick_found && active[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    // The doorbell is looked at directly in IDLE so doorbell-to-request takes two cycles.
    always_comb begin
        state_nxt = state;
        arb_take  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && ((|active) || s_axis_doorbell_valid) &&
                    (inflight_count < CW'(MAX_INFLIGHT)))
                    state_nxt = ST_ARB;
            end
            ST_ARB: begin
                if (pick_found) begin
                    arb_take  = 1'b1;
                    state_nxt = ST_REQ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (req_hs)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Later assignments take priority: a doorbell always leaves the bit set.
    always_comb begin
        active_nxt = active;
        if (arb_take)
            active_nxt[pick_idx] = 1'b0;
        if (resp_hs)
            active_nxt[s_axis_dequeue_resp_queue] = !resp_drop;
        if (s_axis_doorbell_valid)
            active_nxt[s_axis_doorbell_queue] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                    <= ST_IDLE;
            active                   <= '0;
            rr_ptr                   <= '0;
            tag_cnt                  <= '0;
            m_axis_dequeue_req_queue <= '0;
            m_axis_dequeue_req_tag   <= '0;
        end else begin
            state  <= state_nxt;
            active <= active_nxt;
            if (arb_take) begin
                m_axis_dequeue_req_queue <= pick_idx;
                m_axis_dequeue_req_tag   <= tag_cnt;
            end
            if (req_hs) begin
                tag_cnt <= tag_cnt + 1'b1;
                rr_ptr  <= m_axis_dequeue_req_queue + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_count <= '0;
        end else if (req_hs && !resp_hs) begin
            inflight_count <= inflight_count + 1'b1;
        end else if (resp_hs && !req_hs && (inflight_count != '0)) begin
            inflight_count <= inflight_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_desc_req_valid  <= 1'b0;
            m_axis_desc_req_queue  <= '0;
            m_axis_desc_req_ptr    <= '0;
            m_axis_desc_req_addr   <= '0;
            m_axis_desc_req_op_tag <= '0;
        end else if (resp_hs && !resp_drop) begin
            m_axis_desc_req_valid  <= 1'b1;
            m_axis_desc_req_queue  <= s_axis_dequeue_resp_queue;
            m_axis_desc_req_ptr    <= s_axis_dequeue_resp_ptr;
            m_axis_desc_req_addr   <= s_axis_dequeue_resp_addr;
            m_axis_desc_req_op_tag <= s_axis_dequeue_resp_op_tag;
        end else if (m_axis_desc_req_ready) begin
            m_axis_desc_req_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_dequeue_commit_valid  <= 1'b0;
            m_axis_dequeue_commit_op_tag <= '0;
        end else if (done_hs) begin
            m_axis_dequeue_commit_valid  <= 1'b1;
            m_axis_dequeue_commit_op_tag <= s_axis_desc_done_op_tag;
        end else if (m_axis_dequeue_commit_ready) begin
            m_axis_dequeue_commit_valid  <= 1'b0;
        end
    end

`ifdef DEQ_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_req_count   <= '0;
            stat_empty_count <= '0;
            stat_error_count <= '0;
        end else begin
            if (req_hs && (stat_req_count != '1))
                stat_req_count <= stat_req_count + 1'b1;
            if (resp_hs && s_axis_dequeue_resp_empty && (stat_empty_count != '1))
                stat_empty_count <= stat_empty_count + 1'b1;
            if (resp_hs && s_axis_dequeue_resp_error && (stat_error_count != '1))
                stat_error_count <= stat_error_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_queue_dequeue_scheduler.sv
// Bench for queue_dequeue_scheduler: response table plus hand sequences for arbitration, limits and backpressure.
module tb_queue_dequeue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  db_queue = '0;
    logic        db_valid = 1'b0;
    logic [3:0]  req_queue;
    logic [7:0]  req_tag;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [3:0]  resp_queue = '0;
    logic [15:0] resp_ptr = '0;
    logic [63:0] resp_addr = '0;
    logic [7:0]  resp_tag = '0;
    logic [3:0]  resp_op_tag = '0;
    logic        resp_empty = 1'b0;
    logic        resp_error = 1'b0;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [3:0]  desc_queue;
    logic [15:0] desc_ptr;
    logic [63:0] desc_addr;
    logic [3:0]  desc_op_tag;
    logic        desc_valid;
    logic        desc_ready = 1'b1;
    logic [3:0]  done_op_tag = '0;
    logic        done_valid = 1'b0;
    logic        done_ready;
    logic [3:0]  commit_op_tag;
    logic        commit_valid;
    logic        commit_ready = 1'b1;
    logic [3:0]  inflight;

    queue_dequeue_scheduler dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .enable                       (enable),
        .s_axis_doorbell_queue        (db_queue),
        .s_axis_doorbell_valid        (db_valid),
        .m_axis_dequeue_req_queue     (req_queue),
        .m_axis_dequeue_req_tag       (req_tag),
        .m_axis_dequeue_req_valid     (req_valid),
        .m_axis_dequeue_req_ready     (req_ready),
        .s_axis_dequeue_resp_queue    (resp_queue),
        .s_axis_dequeue_resp_ptr      (resp_ptr),
        .s_axis_dequeue_resp_addr     (resp_addr),
        .s_axis_dequeue_resp_tag      (resp_tag),
        .s_axis_dequeue_resp_op_tag   (resp_op_tag),
        .s_axis_dequeue_resp_empty    (resp_empty),
        .s_axis_dequeue_resp_error    (resp_error),
        .s_axis_dequeue_resp_valid    (resp_valid),
        .s_axis_dequeue_resp_ready    (resp_ready),
        .m_axis_desc_req_queue        (desc_queue),
        .m_axis_desc_req_ptr          (desc_ptr),
        .m_axis_desc_req_addr         (desc_addr),
        .m_axis_desc_req_op_tag       (desc_op_tag),
        .m_axis_desc_req_valid        (desc_valid),
        .m_axis_desc_req_ready        (desc_ready),
        .s_axis_desc_done_op_tag      (done_op_tag),
        .s_axis_desc_done_valid       (done_valid),
        .s_axis_desc_done_ready       (done_ready),
        .m_axis_dequeue_commit_op_tag (commit_op_tag),
        .m_axis_dequeue_commit_valid  (commit_valid),
        .m_axis_dequeue_commit_ready  (commit_ready),
        .inflight_count               (inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  q;
        logic [15:0] ptr;
        logic [63:0] addr;
        logic [3:0]  op;
        logic        empty;
        logic        error;
        logic        fwd;
    } vec_t;

    typedef struct {
        logic [3:0]  q;
        logic [15:0] ptr;
        logic [63:0] addr;
        logic [3:0]  op;
    } desc_t;

    desc_t      sb[$];
    vec_t       vecs[4];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_tag = '0;
    logic [7:0] last_tag = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0; db_valid = 1'b0; resp_valid = 1'b0; done_valid = 1'b0;
        req_ready = 1'b1; desc_ready = 1'b1; commit_ready = 1'b1;
        sb.delete();
        exp_tag = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic doorbell(input logic [3:0] q);
        db_queue = q; db_valid = 1'b1;
        @(negedge clk);
        db_valid = 1'b0;
    endtask

    // Returns at the negedge where the request is visible; handshake happens at the next posedge.
    task automatic expect_req(input logic [3:0] q, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (req_valid) seen = 1'b1;
            else @(negedge clk);
        end
        check({name, "_req_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({name, "_req_queue"}, 64'(req_queue), 64'(q));
            check({name, "_req_tag"}, 64'(req_tag), 64'(exp_tag));
            last_tag = exp_tag;
            exp_tag++;
        end
    endtask

    task automatic send_resp(input logic [3:0] q, input logic [15:0] ptr, input logic [63:0] addr,
                             input logic [3:0] op, input logic empty, input logic error, input logic fwd);
        desc_t d;
        resp_queue = q; resp_ptr = ptr; resp_addr = addr; resp_op_tag = op;
        resp_empty = empty; resp_error = error; resp_tag = last_tag; resp_valid = 1'b1;
        if (fwd) begin
            d.q = q; d.ptr = ptr; d.addr = addr; d.op = op;
            sb.push_back(d);
        end
        @(negedge clk);
        resp_valid = 1'b0;
    endtask

    task automatic check_desc(input logic fwd, input string name);
        desc_t d;
        check({name, "_desc_valid"}, 64'(desc_valid), 64'(fwd));
        if (fwd && desc_valid && sb.size() > 0) begin
            d = sb.pop_front();
            check({name, "_desc_queue"}, 64'(desc_queue), 64'(d.q));
            check({name, "_desc_ptr"}, 64'(desc_ptr), 64'(d.ptr));
            check({name, "_desc_addr"}, desc_addr, d.addr);
            check({name, "_desc_op"}, 64'(desc_op_tag), 64'(d.op));
        end
    endtask

    task automatic quiet(input int n, input string name);
        bit seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (req_valid) seen = 1'b1;
        end
        check({name, "_no_req"}, 64'(seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_order[3];
        int cnt;

        vecs[0] = '{q: 4'd6,  ptr: 16'h1234, addr: 64'hDEAD_BEEF_0000_1000, op: 4'h3, empty: 1'b0, error: 1'b0, fwd: 1'b1};
        vecs[1] = '{q: 4'd12, ptr: 16'h0001, addr: 64'h0000_0000_0000_2000, op: 4'h7, empty: 1'b1, error: 1'b0, fwd: 1'b0};
        vecs[2] = '{q: 4'd0,  ptr: 16'hFFFF, addr: 64'hFFFF_FFFF_FFFF_FFF0, op: 4'hF, empty: 1'b0, error: 1'b1, fwd: 1'b0};
        vecs[3] = '{q: 4'd15, ptr: 16'h8000, addr: 64'h8000_0000_0000_0000, op: 4'h1, empty: 1'b1, error: 1'b1, fwd: 1'b0};

        do_reset();
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_desc_valid", 64'(desc_valid), 64'd0);
        check("rst_commit_valid", 64'(commit_valid), 64'd0);
        check("rst_inflight", 64'(inflight), 64'd0);
        check("rst_req_tag", 64'(req_tag), 64'd0);
        check("rst_resp_ready", 64'(resp_ready), 64'd1);
        check("rst_done_ready", 64'(done_ready), 64'd1);

        // Doorbell latency: request must appear exactly two cycles after the doorbell.
        enable = 1'b1;
        doorbell(4'd3);
        check("lat_cycle1_req_valid", 64'(req_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2_req_valid", 64'(req_valid), 64'd1);
        expect_req(4'd3, "lat");
        @(negedge clk);
        check("lat_inflight_one", 64'(inflight), 64'd1);
        send_resp(4'd3, 16'h0, 64'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("lat_inflight_zero", 64'(inflight), 64'd0);
        check_desc(1'b0, "lat");

        for (int v = 0; v < 4; v++) begin
            doorbell(vecs[v].q);
            expect_req(vecs[v].q, "vec");
            send_resp(vecs[v].q, vecs[v].ptr, vecs[v].addr, vecs[v].op, vecs[v].empty, vecs[v].error, vecs[v].fwd);
            check_desc(vecs[v].fwd, "vec");
            if (vecs[v].fwd) begin
                expect_req(vecs[v].q, "vec_repoll");
                send_resp(vecs[v].q, 16'h0, 64'h0, 4'h0, 1'b1, 1'b0, 1'b0);
                check_desc(1'b0, "vec_repoll");
            end
            quiet(8, "vec");
            check("vec_inflight", 64'(inflight), 64'd0);
        end

        // Empty response and doorbell for the same queue in one cycle: the doorbell must win.
        doorbell(4'd5);
        expect_req(4'd5, "dbwin_first");
        db_queue = 4'd5; db_valid = 1'b1;
        send_resp(4'd5, 16'h0, 64'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        db_valid = 1'b0;
        expect_req(4'd5, "dbwin_again");
        send_resp(4'd5, 16'h0, 64'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        quiet(8, "dbwin");

        // Round robin over 1,5,9: six non-empty responses, then three empty ones drain the bitmap.
        do_reset();
        rr_order[0] = 4'd1; rr_order[1] = 4'd5; rr_order[2] = 4'd9;
        doorbell(4'd1); doorbell(4'd5); doorbell(4'd9);
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            expect_req(rr_order[i % 3], "rr");
            send_resp(rr_order[i % 3], 16'h0100 + 16'(i), 64'hA000_0000_0000_0000 + 64'(i),
                      4'(i + 2), (i >= 6), 1'b0, (i < 6));
            check_desc((i < 6), "rr");
        end
        quiet(10, "rr_drain");

        // Inflight limit with all 16 queues active and no responses.
        do_reset();
        for (int q = 0; q < 16; q++) doorbell(4'(q));
        enable = 1'b1;
        cnt = 0;
        repeat (80) begin
            if (req_valid) cnt++;
            @(negedge clk);
        end
        check("max_req_count", 64'(cnt), 64'd8);
        check("max_inflight", 64'(inflight), 64'd8);
        check("max_req_valid_low", 64'(req_valid), 64'd0);
        send_resp(4'd0, 16'h0, 64'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        cnt = 0;
        repeat (30) begin
            if (req_valid) cnt++;
            @(negedge clk);
        end
        check("max_one_more_req", 64'(cnt), 64'd1);
        check("max_inflight_again", 64'(inflight), 64'd8);

        // Descriptor backpressure stalls the response channel.
        do_reset();
        enable = 1'b1;
        doorbell(4'd2);
        expect_req(4'd2, "bp_a");
        @(negedge clk);
        doorbell(4'd7);
        expect_req(4'd7, "bp_b");
        enable = 1'b0;
        desc_ready = 1'b0;
        send_resp(4'd2, 16'h0022, 64'h0000_0000_0000_2222, 4'h2, 1'b0, 1'b0, 1'b1);
        check_desc(1'b1, "bp_first");
        resp_queue = 4'd7; resp_ptr = 16'h0077; resp_addr = 64'h7777; resp_op_tag = 4'h7;
        resp_empty = 1'b0; resp_error = 1'b0; resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_resp_ready_low", 64'(resp_ready), 64'd0);
            check("bp_desc_held_queue", 64'(desc_queue), 64'd2);
            @(negedge clk);
        end
        desc_ready = 1'b1;
        #1;
        check("bp_resp_ready_high", 64'(resp_ready), 64'd1);
        @(negedge clk);
        resp_valid = 1'b0;
        check("bp_second_valid", 64'(desc_valid), 64'd1);
        check("bp_second_queue", 64'(desc_queue), 64'd7);
        check("bp_second_ptr", 64'(desc_ptr), 64'h0077);
        @(negedge clk);
        check("bp_drained", 64'(desc_valid), 64'd0);

        // Commit held under backpressure.
        commit_ready = 1'b0;
        done_op_tag = 4'hA; done_valid = 1'b1;
        @(negedge clk);
        done_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("cm_valid", 64'(commit_valid), 64'd1);
            check("cm_op_tag", 64'(commit_op_tag), 64'hA);
            check("cm_done_ready_low", 64'(done_ready), 64'd0);
            @(negedge clk);
        end
        commit_ready = 1'b1;
        #1;
        check("cm_done_ready_high", 64'(done_ready), 64'd1);
        @(negedge clk);
        check("cm_released", 64'(commit_valid), 64'd0);

        // Asynchronous reset drops a pending commit immediately.
        commit_ready = 1'b0;
        done_op_tag = 4'h5; done_valid = 1'b1;
        @(negedge clk);
        done_valid = 1'b0;
        check("arst_commit_before", 64'(commit_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_commit_dropped", 64'(commit_valid), 64'd0);
        check("arst_inflight", 64'(inflight), 64'd0);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
